// File: rtl/vga_fb_ctrl.sv
// VGA scan generator with a single- or double-buffered frame store.
// Two pix_ce-gated output stages (RAM read, output register) keep rgb, de and syncs aligned.
module vga_fb_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int BPP             = 3,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int DOUBLE_BUF      = 1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int AW      = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           pix_ce,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [BPP-1:0] wr_data,
  input  logic           swap_req,
  output logic           swap_pending,
  output logic           front_sel,
  output logic           vblank,
  output logic           frame_start,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [BPP-1:0] rgb
);

  localparam int NPIX  = H_ACTIVE * V_ACTIVE;
  localparam int DEPTH = (1 + DOUBLE_BUF) * NPIX;
  localparam int IW    = $clog2(DEPTH);
  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [IW-1:0] BUF1_BASE = IW'(NPIX);
  localparam logic [AW:0]   NPIX_W    = (AW+1)'(NPIX);
  localparam logic          SYNC_INV  = (SYNC_ACTIVE_LOW != 0);
  localparam logic          DBUF      = (DOUBLE_BUF != 0);

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [AW-1:0]  rd_addr;
  logic           h_last, v_last, wrap, active;
  logic           hs_raw, vs_raw;
  logic [IW-1:0]  rd_base, wr_base;
  logic           wr_ok;

  logic [BPP-1:0] mem [DEPTH];
  logic [BPP-1:0] rd_data_p0;
  logic           vld_p0, hs_p0, vs_p0;
  logic [BPP-1:0] rgb_p1;
  logic           vld_p1, hs_p1, vs_p1;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign wrap   = pix_ce && h_last && v_last;
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign vblank = (v_cnt >= V_ACT);

  // Buffer 1 sits directly above buffer 0; the display reads front, writes go to the other.
  assign rd_base = (DBUF && front_sel)  ? BUF1_BASE : '0;
  assign wr_base = (DBUF && !front_sel) ? BUF1_BASE : '0;
  assign wr_ok   = ({1'b0, wr_addr} < NPIX_W);

  always_ff @(posedge clk) begin
    if (srst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      rd_addr <= '0;
    end else if (pix_ce) begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      if (wrap)
        rd_addr <= '0;
      else if (active)
        rd_addr <= rd_addr + AW'(1);
    end
  end

  // A request on the wrap clock itself is honoured at that wrap; repeats coalesce.
  always_ff @(posedge clk) begin
    if (srst || !DBUF) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (wrap && (swap_pending || swap_req)) begin
      front_sel    <= ~front_sel;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      frame_start <= 1'b0;
    else
      frame_start <= wrap;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !srst && wr_ok)
      mem[wr_base + IW'(wr_addr)] <= wr_data;
  end

  // Stage p0: registered RAM read, scan controls captured alongside
  always_ff @(posedge clk) begin
    if (pix_ce && active)
      rd_data_p0 <= mem[rd_base + IW'(rd_addr)];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      vld_p0 <= 1'b0;
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
    end else if (pix_ce) begin
      vld_p0 <= active;
      hs_p0  <= hs_raw;
      vs_p0  <= vs_raw;
    end
  end

  // Stage p1: output register, pixel forced to 0 outside the active area
  always_ff @(posedge clk) begin
    if (srst) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      rgb_p1 <= '0;
    end else if (pix_ce) begin
      vld_p1 <= vld_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      rgb_p1 <= vld_p0 ? rd_data_p0 : '0;
    end
  end

  assign de    = vld_p1;
  assign rgb   = rgb_p1;
  assign hsync = hs_p1 ^ SYNC_INV;
  assign vsync = vs_p1 ^ SYNC_INV;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Scoreboard bench for vga_fb_ctrl on a 14x7 total / 8x4 active raster.
// Timing expectations are keyed on clocks since reset release; pixel expectations pop on de.
module tb_vga_fb_ctrl;
  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam int BPP = 3;
  localparam int AW = 5;

  localparam int S_DE = 0, S_HS = 1, S_VS = 2, S_FS = 3, S_VB = 4, S_FSEL = 5, S_SP = 6;

  logic clk = 1'b0;
  logic srst, pix_ce, wr_en, swap_req;
  logic [AW-1:0] wr_addr;
  logic [BPP-1:0] wr_data;
  logic swap_pending, front_sel, vblank, frame_start, hsync, vsync, de;
  logic [BPP-1:0] rgb;

  always #5 clk = ~clk;

  vga_fb_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(V_ACTIVE), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BPP(BPP), .SYNC_ACTIVE_LOW(1), .DOUBLE_BUF(1)
  ) dut (
    .clk(clk), .srst(srst), .pix_ce(pix_ce),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_pending(swap_pending), .front_sel(front_sel),
    .vblank(vblank), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
  );

  typedef struct {
    int n;
    int s;
    int v;
  } tchk_t;

  tchk_t tq[$];
  int    pixq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    pix_en = 1'b0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic string sig_name(int s);
    case (s)
      S_DE:    return "de";
      S_HS:    return "hsync";
      S_VS:    return "vsync";
      S_FS:    return "frame_start";
      S_VB:    return "vblank";
      S_FSEL:  return "front_sel";
      default: return "swap_pending";
    endcase
  endfunction

  function automatic int sig_val(int s);
    case (s)
      S_DE:    return int'(de);
      S_HS:    return int'(hsync);
      S_VS:    return int'(vsync);
      S_FS:    return int'(frame_start);
      S_VB:    return int'(vblank);
      S_FSEL:  return int'(front_sel);
      default: return int'(swap_pending);
    endcase
  endfunction

  task automatic pt(int n, int s, int v);
    tchk_t t;
    t.n = n;
    t.s = s;
    t.v = v;
    tq.push_back(t);
  endtask

  task automatic to_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= srst ? 0 : cyc + 1;

  // Monitor: timing scoreboard plus pixel scoreboard popped on de
  tchk_t mt;
  always @(negedge clk) begin
    while (tq.size() > 0 && cyc > 0 && tq[0].n <= cyc) begin
      mt = tq.pop_front();
      if (mt.n < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_%s@%0d: now at %0d", sig_name(mt.s), mt.n, cyc);
      end else begin
        chk($sformatf("%s@%0d", sig_name(mt.s), mt.n), sig_val(mt.s), mt.v);
      end
    end
    if (pix_en) begin
      if (de) begin
        if (pixq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pix_extra@%0d: got rgb %0d with nothing expected", cyc, rgb);
        end else begin
          chk($sformatf("pix@%0d", cyc), int'(rgb), pixq.pop_front());
        end
      end else begin
        chk($sformatf("rgb_blank@%0d", cyc), int'(rgb), 0);
      end
    end
  end

  initial begin
    srst = 1'b1; pix_ce = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_de", de, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_fsel", front_sel, 0);
    chk("rst_sp", swap_pending, 0);
    chk("rst_vblank", vblank, 0);

    // Raster timing for three frames, with two swaps
    pt(2, S_DE, 1);    pt(9, S_DE, 1);    pt(10, S_DE, 0);   pt(11, S_HS, 1);
    pt(12, S_HS, 0);   pt(13, S_HS, 0);   pt(14, S_HS, 1);   pt(26, S_HS, 0);
    pt(40, S_SP, 0);   pt(41, S_SP, 1);   pt(46, S_SP, 1);   pt(55, S_VB, 0);
    pt(56, S_VB, 1);   pt(71, S_VS, 1);   pt(72, S_VS, 0);   pt(85, S_VS, 0);
    pt(86, S_VS, 1);   pt(97, S_FS, 0);   pt(97, S_VB, 1);   pt(97, S_FSEL, 0);
    pt(97, S_SP, 1);   pt(98, S_FS, 1);   pt(98, S_VB, 0);   pt(98, S_FSEL, 1);
    pt(98, S_SP, 0);   pt(99, S_FS, 0);   pt(195, S_SP, 0);  pt(195, S_FSEL, 1);
    pt(196, S_FS, 1);  pt(196, S_FSEL, 0); pt(196, S_SP, 0); pt(197, S_SP, 0);

    srst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = BPP'(i % 8);
      @(negedge clk);
    end
    wr_en = 1'b0;
    to_cyc(40);
    swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
    to_cyc(45);
    swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;

    to_cyc(98);
    for (int i = 0; i < 32; i++) pixq.push_back(i % 8);
    for (int i = 0; i < 32; i++) pixq.push_back(7 - (i % 8));
    pix_en = 1'b1;

    // Fill buffer 0 while buffer 1 is on screen
    to_cyc(100);
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = BPP'(7 - (i % 8));
      @(negedge clk);
    end
    wr_en = 1'b0;
    to_cyc(195);
    swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
    to_cyc(260);
    pix_en = 1'b0;
    chk("pix_left", pixq.size(), 0);

    // Reset in line 2 with a swap pending
    to_cyc(324);
    swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
    chk("sp_before_rst", swap_pending, 1);
    srst = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 3'd5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("rst2_de", de, 0);
    chk("rst2_rgb", rgb, 0);
    chk("rst2_hsync", hsync, 1);
    chk("rst2_vsync", vsync, 1);
    chk("rst2_fs", frame_start, 0);
    chk("rst2_sp", swap_pending, 0);
    chk("rst2_fsel", front_sel, 0);
    chk("rst2_vblank", vblank, 0);
    chk("tq_empty_rst2", tq.size(), 0);
    pt(2, S_DE, 1);    pt(9, S_DE, 1);    pt(10, S_DE, 0);   pt(12, S_HS, 0);
    pt(14, S_HS, 1);   pt(72, S_VS, 0);   pt(86, S_VS, 1);   pt(97, S_FS, 0);
    pt(98, S_FS, 1);   pt(98, S_FSEL, 0); pt(98, S_SP, 0);
    srst = 1'b0;
    to_cyc(100);

    // Half-rate pixel enable
    srst = 1'b1;
    @(negedge clk);
    pt(2, S_DE, 0);    pt(3, S_DE, 1);    pt(18, S_DE, 1);   pt(19, S_DE, 0);
    pt(22, S_HS, 1);   pt(23, S_HS, 0);   pt(26, S_HS, 0);   pt(27, S_HS, 1);
    pt(50, S_HS, 1);   pt(51, S_HS, 0);   pt(54, S_HS, 0);   pt(55, S_HS, 1);
    pt(194, S_FS, 0);  pt(195, S_FS, 1);  pt(196, S_FS, 0);
    srst = 1'b0;
    pix_ce = 1'b1;
    while (cyc < 200) begin
      @(negedge clk);
      pix_ce = ~cyc[0];
    end
    pix_ce = 1'b1;
    @(negedge clk);
    chk("tq_left", tq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
